// File: rtl/cacheline_burst_adaptor.sv
// Bridges the L2 line interface to a beat-serialised memory port.
// A line transfer is split into LINE_W/BURST_W beats, one per resp_i.
module cacheline_burst_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [31:0]        address_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  output logic               read_o,
  output logic               write_o,
  output logic [31:0]        address_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               resp_i
);

  localparam int BURST_LEN = LINE_W / BURST_W;
  localparam int CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int OFF_W     = $clog2(LINE_W / 8);
  localparam logic [31:0]      ALIGN_MASK = ~((32'd1 << OFF_W) - 32'd1);
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [LINE_W-1:0]  r_wbuf;

  logic               w_last;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [31:0]        w_addr_aligned;

  assign w_last         = (r_count == LAST_BEAT);
  assign w_count_nxt    = r_count + 1'b1;
  assign w_addr_aligned = address_i & ALIGN_MASK;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_wbuf    <= '0;
      line_o    <= '0;
      resp_o    <= 1'b0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      address_o <= '0;
      burst_o   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          resp_o <= 1'b0;
          // read wins so a fill is never stalled behind a simultaneous writeback
          if (read_i) begin
            address_o <= w_addr_aligned;
            r_count   <= '0;
            read_o    <= 1'b1;
            r_state   <= READ;
          end else if (write_i) begin
            address_o <= w_addr_aligned;
            r_count   <= '0;
            r_wbuf    <= line_i;
            burst_o   <= line_i[BURST_W-1:0];
            write_o   <= 1'b1;
            r_state   <= WRITE;
          end
        end
        READ: begin
          if (resp_i) begin
            line_o[int'(r_count)*BURST_W +: BURST_W] <= burst_i;
            r_count <= w_count_nxt;
            if (w_last) begin
              r_count <= '0;
              read_o  <= 1'b0;
              resp_o  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            r_count <= w_count_nxt;
            if (w_last) begin
              r_count <= '0;
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              r_state <= DONE;
            end else begin
              burst_o <= r_wbuf[int'(w_count_nxt)*BURST_W +: BURST_W];
            end
          end
        end
        DONE: begin
          resp_o  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed bench for cacheline_burst_adaptor: read, gapped write,
// writeback-then-fill, request priority, mid-burst reset, stray resp_i.
module tb_cacheline_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic         read_i, write_i, resp_i;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o, read_o, write_o;
  logic [31:0]  address_o;
  logic [63:0]  burst_o, burst_i;

  int pass_cnt = 0;
  int total    = 0;

  localparam logic [63:0] B0 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B1 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B2 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B3 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] D0 = 64'hA0A0_0000_0000_00D0;
  localparam logic [63:0] D1 = 64'hA1A1_0000_0000_00D1;
  localparam logic [63:0] D2 = 64'hA2A2_0000_0000_00D2;
  localparam logic [63:0] D3 = 64'hA3A3_0000_0000_00D3;
  localparam logic [63:0] F0 = 64'h5555_0000_AAAA_0000;
  localparam logic [63:0] F1 = 64'h6666_0000_BBBB_0001;
  localparam logic [63:0] F2 = 64'h7777_0000_CCCC_0002;
  localparam logic [63:0] F3 = 64'h8888_0000_DDDD_0003;

  cacheline_burst_adaptor dut (
    .clk(clk), .rst(rst), .read_i(read_i), .write_i(write_i),
    .address_i(address_i), .line_i(line_i), .line_o(line_o),
    .resp_o(resp_o), .read_o(read_o), .write_o(write_o),
    .address_o(address_o), .burst_o(burst_o), .burst_i(burst_i),
    .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    logic [63:0] beats [4];
    logic [1:0]  wpat  [7];
    logic [63:0] wexp  [7];

    rst = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = 32'hFFFF_FFFF; line_i = '1; burst_i = '1;
    tick();
    chk1("rst_read_o", read_o, 1'b0);
    chk1("rst_write_o", write_o, 1'b0);
    chk1("rst_resp_o", resp_o, 1'b0);
    chk32("rst_addr", address_o, 32'h0);
    chk64("rst_burst", burst_o, 64'h0);
    chkw("rst_line", line_o, 256'h0);

    // Zero-wait read: request in cycle 0, beats cycles 1-4, resp_o cycle 5
    rst = 1'b1; read_i = 1'b1; address_i = 32'h0000_1234;
    tick();
    chk1("rd_start_read_o", read_o, 1'b1);
    chk32("rd_addr", address_o, 32'h0000_1220);
    read_i = 1'b0; address_i = 32'h0;
    beats[0] = B0; beats[1] = B1; beats[2] = B2; beats[3] = B3;
    for (int i = 0; i < 4; i++) begin
      chk1("rd_resp_o_low", resp_o, 1'b0);
      chk1("rd_read_o_high", read_o, 1'b1);
      resp_i = 1'b1; burst_i = beats[i];
      tick();
    end
    resp_i = 1'b0; burst_i = '0;
    chk1("rd_done_resp_o", resp_o, 1'b1);
    chk1("rd_done_read_o", read_o, 1'b0);
    chkw("rd_line", line_o, {B3, B2, B1, B0});
    tick();
    chk1("rd_resp_o_single", resp_o, 1'b0);

    // Write with gaps in resp_i
    write_i = 1'b1; address_i = 32'h0000_ABCD; line_i = {D3, D2, D1, D0};
    tick();
    chk1("wr_write_o", write_o, 1'b1);
    chk32("wr_addr", address_o, 32'h0000_ABC0);
    chk64("wr_beat0", burst_o, D0);
    write_i = 1'b0; line_i = '0;
    wpat[0] = 2'd1; wpat[1] = 2'd0; wpat[2] = 2'd1; wpat[3] = 2'd0;
    wpat[4] = 2'd0; wpat[5] = 2'd1; wpat[6] = 2'd1;
    wexp[0] = D1; wexp[1] = D1; wexp[2] = D2; wexp[3] = D2;
    wexp[4] = D2; wexp[5] = D3; wexp[6] = D3;
    for (int i = 0; i < 6; i++) begin
      resp_i = wpat[i][0];
      tick();
      chk64("wr_burst", burst_o, wexp[i]);
      chk1("wr_write_o_held", write_o, 1'b1);
      chk1("wr_resp_o_low", resp_o, 1'b0);
    end
    resp_i = wpat[6][0];
    tick();
    resp_i = 1'b0;
    chk1("wr_done_resp_o", resp_o, 1'b1);
    chk1("wr_done_write_o", write_o, 1'b0);
    chkw("wr_line_o_untouched", line_o, {B3, B2, B1, B0});

    // Allocate immediately after writeback completes
    read_i = 1'b1; address_i = 32'h0000_205F;
    tick();
    chk1("wb_idle_resp_o", resp_o, 1'b0);
    chk1("wb_idle_read_o", read_o, 1'b0);
    tick();
    chk1("wb_alloc_read_o", read_o, 1'b1);
    chk32("wb_alloc_addr", address_o, 32'h0000_2040);
    read_i = 1'b0;
    beats[0] = F0; beats[1] = F1; beats[2] = F2; beats[3] = F3;
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1; burst_i = beats[i];
      tick();
    end
    resp_i = 1'b0;
    chk1("wb_alloc_resp_o", resp_o, 1'b1);
    chkw("wb_alloc_line", line_o, {F3, F2, F1, F0});
    tick();

    // Simultaneous read and write: read wins, write_o never rises
    read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_3000; line_i = '1;
    tick();
    chk1("prio_read_o", read_o, 1'b1);
    chk1("prio_write_o", write_o, 1'b0);
    read_i = 1'b0; write_i = 1'b0;
    beats[0] = B3; beats[1] = B2; beats[2] = B1; beats[3] = B0;
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1; burst_i = beats[i];
      tick();
      chk1("prio_write_o_low", write_o, 1'b0);
    end
    resp_i = 1'b0;
    chkw("prio_line", line_o, {B0, B1, B2, B3});
    tick();

    // Stray resp_i while idle
    resp_i = 1'b1; burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("idle_resp_o", resp_o, 1'b0);
      chk1("idle_read_o", read_o, 1'b0);
    end
    chkw("idle_line", line_o, {B0, B1, B2, B3});
    resp_i = 1'b0;

    // Reset after three beats of a read abandons the burst
    read_i = 1'b1; address_i = 32'h0000_4000;
    tick();
    read_i = 1'b0;
    beats[0] = D0; beats[1] = D1; beats[2] = D2;
    for (int i = 0; i < 3; i++) begin
      resp_i = 1'b1; burst_i = beats[i];
      tick();
    end
    rst = 1'b0; resp_i = 1'b0;
    tick();
    chk1("mid_rst_read_o", read_o, 1'b0);
    chk1("mid_rst_resp_o", resp_o, 1'b0);
    chk32("mid_rst_addr", address_o, 32'h0);
    chkw("mid_rst_line", line_o, 256'h0);
    rst = 1'b1;
    tick();
    chk1("post_rst_resp_o", resp_o, 1'b0);
    read_i = 1'b1; address_i = 32'h0000_5010;
    tick();
    chk32("post_rst_addr", address_o, 32'h0000_5000);
    read_i = 1'b0;
    beats[0] = F3; beats[1] = F2; beats[2] = F1; beats[3] = F0;
    for (int i = 0; i < 4; i++) begin
      chk1("post_rst_resp_low", resp_o, 1'b0);
      resp_i = 1'b1; burst_i = beats[i];
      tick();
    end
    resp_i = 1'b0;
    chk1("post_rst_resp_o_done", resp_o, 1'b1);
    chkw("post_rst_line", line_o, {F0, F1, F2, F3});
    tick();
    chk1("post_rst_resp_o_end", resp_o, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
